// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared load/store encodings, MEM FSM states and alignment check
package mem_pkg;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  localparam logic [1:0] ST_SB = 2'b00;
  localparam logic [1:0] ST_SH = 2'b01;
  localparam logic [1:0] ST_SW = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_RSP  = 2'b10
  } mem_state_e;

  // Stores take precedence over the load type when both request bits are set.
  function automatic logic is_misaligned(input logic       is_store,
                                         input logic [2:0] load_type,
                                         input logic [1:0] store_type,
                                         input logic [1:0] addr_lo);
    logic r;
    r = 1'b0;
    if (is_store) begin
      case (store_type)
        ST_SH:   r = addr_lo[0];
        ST_SW:   r = |addr_lo;
        default: r = 1'b0;
      endcase
    end else begin
      case (load_type)
        LT_LH, LT_LHU: r = addr_lo[0];
        LT_LW:         r = |addr_lo;
        default:       r = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - aligns a read word to the byte offset and sign/zero-extends it
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [31:0] w_shifted;

  assign w_shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = w_shifted;
    case (load_type)
      LT_LB:   data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LT_LH:   data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LT_LBU:  data = {24'h000000, w_shifted[7:0]};
      LT_LHU:  data = {16'h0000, w_shifted[15:0]};
      default: data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: valid/ready data-memory access,
// load alignment and the MEM/WB register.
module mem_access_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] rs2_data_mem,
  input  logic [4:0]  rd_mem,
  input  logic        mem_read_mem,
  input  logic        mem_write_mem,
  input  logic [2:0]  mem_load_type_mem,
  input  logic [1:0]  mem_store_type_mem,
  input  logic        wb_reg_file_mem,
  input  logic        memtoreg_mem,
  output logic [31:0] data_forward_mem,
  output logic        stall_mem,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        valid_wb,
  output logic [4:0]  rd_wb,
  output logic        wb_reg_file_wb,
  output logic        memtoreg_wb,
  output logic [31:0] alu_result_wb,
  output logic [31:0] load_data_wb,
  output logic        misaligned_wb
);

  mem_state_e  r_state;
  mem_state_e  w_state_nxt;
  logic [1:0]  r_offset;
  logic [2:0]  r_load_type;

  logic        w_mem_op;
  logic        w_misaligned;
  logic        w_aligned_op;
  logic        w_req_valid;
  logic        w_done;
  logic        w_accept;
  logic        w_load_done;
  logic [31:0] w_load_data;

  assign data_forward_mem = alu_result_mem;

  assign w_mem_op     = valid_mem & (mem_read_mem | mem_write_mem);
  assign w_misaligned = w_mem_op & is_misaligned(mem_write_mem, mem_load_type_mem,
                                                 mem_store_type_mem, alu_result_mem[1:0]);
  assign w_aligned_op = w_mem_op & ~w_misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_valid = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_aligned_op) begin
          w_req_valid = 1'b1;
          if (dmem_req_ready) begin
            if (mem_write_mem) w_done = 1'b1;
            else               w_state_nxt = S_RSP;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        w_req_valid = 1'b1;
        if (dmem_req_ready) begin
          if (mem_write_mem) begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_RSP;
          end
        end
      end
      S_RSP: begin
        if (dmem_rsp_valid) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign dmem_req_valid = w_req_valid;
  assign stall_mem      = w_aligned_op & ~w_done;
  assign w_accept       = w_req_valid & dmem_req_ready;
  assign w_load_done    = w_aligned_op & mem_read_mem & ~mem_write_mem;

  assign dmem_addr = {alu_result_mem[31:2], 2'b00};
  assign dmem_we   = mem_write_mem;

  always_comb begin
    dmem_wdata = rs2_data_mem;
    dmem_wstrb = 4'b0000;
    if (mem_write_mem) begin
      case (mem_store_type_mem)
        ST_SB: begin
          dmem_wdata = {4{rs2_data_mem[7:0]}};
          dmem_wstrb = 4'b0001 << alu_result_mem[1:0];
        end
        ST_SH: begin
          dmem_wdata = {2{rs2_data_mem[15:0]}};
          dmem_wstrb = 4'b0011 << alu_result_mem[1:0];
        end
        default: begin
          dmem_wdata = rs2_data_mem;
          dmem_wstrb = 4'b1111;
        end
      endcase
    end
  end

  // Offset and type are latched at acceptance so extraction does not depend on EX/MEM later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_offset    <= 2'b00;
      r_load_type <= 3'b000;
    end else if (w_accept && !mem_write_mem) begin
      r_offset    <= alu_result_mem[1:0];
      r_load_type <= mem_load_type_mem;
    end
  end

  load_extend u_load_extend (
    .rdata     (dmem_rdata),
    .offset    (r_offset),
    .load_type (r_load_type),
    .data      (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_wb       <= 1'b0;
      rd_wb          <= 5'd0;
      wb_reg_file_wb <= 1'b0;
      memtoreg_wb    <= 1'b0;
      alu_result_wb  <= 32'd0;
      load_data_wb   <= 32'd0;
      misaligned_wb  <= 1'b0;
    end else if (stall_mem) begin
      valid_wb       <= 1'b0;
      wb_reg_file_wb <= 1'b0;
      memtoreg_wb    <= 1'b0;
      misaligned_wb  <= 1'b0;
    end else begin
      valid_wb       <= valid_mem;
      rd_wb          <= rd_mem;
      wb_reg_file_wb <= valid_mem & wb_reg_file_mem & ~w_misaligned;
      memtoreg_wb    <= valid_mem & memtoreg_mem & ~w_misaligned;
      alu_result_wb  <= alu_result_mem;
      load_data_wb   <= w_load_done ? w_load_data : 32'd0;
      misaligned_wb  <= w_misaligned;
    end
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage sitting directly downstream of the EX stage's EX/MEM register. It turns the ALU result, the store data and the memory control bits into a valid/ready data-memory transaction, and aligns and extends load data. It owns the MEM/WB pipeline register and asserts a stall toward the hazard unit while a memory access is outstanding.

## Interface
- No parameters. Width is fixed at 32 bits.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_mem  in  1  the EX/MEM register holds a real instruction.
- alu_result_mem  in  32  effective address, or the ALU result for non-memory ops.
- rs2_data_mem  in  32  store data, already forwarded.
- rd_mem  in  5  destination register.
- mem_read_mem, mem_write_mem  in  1 each  load / store request.
- mem_load_type_mem  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_store_type_mem  in  2  00 SB, 01 SH, 10 SW.
- wb_reg_file_mem, memtoreg_mem  in  1 each  writeback controls.
- data_forward_mem  out  32  alu_result_mem, combinational, for the EX forwarding mux.
- stall_mem  out  1  holds the IF through EX/MEM registers.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_addr  out  32  word address, {alu_result_mem[31:2], 2'b00}.
- dmem_we  out  1  1 = write.
- dmem_wstrb  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rsp_valid  in  1  read data valid.
- dmem_rdata  in  32  read data.
- valid_wb, rd_wb, wb_reg_file_wb, memtoreg_wb, alu_result_wb[31:0], load_data_wb[31:0]  out  the MEM/WB register.
- misaligned_wb  out  1  one-cycle flag in WB marking an aborted misaligned access.

## Operation
- The block is a memory op when valid_mem is 1 and either mem_read_mem or mem_write_mem is 1.
- Misaligned accesses:
  - LH, LHU or SH with addr[0] set.
  - LW or SW with addr[1:0] nonzero.
  - A misaligned op issues no request and does not stall. It enters WB with wb_reg_file_wb forced to 0 and misaligned_wb set to 1.
- FSM states are IDLE, REQ and RSP.
  - IDLE: an aligned memory op drives dmem_req_valid combinationally.
    - If the request is accepted and it is a store, the op completes this cycle.
    - If the request is accepted and it is a load, the FSM moves to RSP.
    - If the request is not accepted, the FSM moves to REQ.
  - REQ: dmem_req_valid is held at 1. On acceptance, a store completes and goes to IDLE; a load goes to RSP.
  - RSP: dmem_req_valid is 0. When dmem_rsp_valid is 1, the load completes and the FSM goes to IDLE.
- stall_mem is 1 whenever an aligned memory op is present and not completing this cycle. It is never 1 for non-memory ops.
- Store lanes, where o = addr[1:0]:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 4'b0001 << o.
  - SH: wdata = {2{rs2[15:0]}}, wstrb = 4'b0011 << o.
  - SW: wdata = rs2, wstrb = 4'b1111.
  - dmem_we = mem_write_mem.
- Load extraction:
  - The byte offset and load type are registered at request acceptance.
  - Shift dmem_rdata right by 8*offset, then sign- or zero-extend according to the type.
- dmem_rsp_valid is ignored in IDLE and REQ.

## Timing
- MEM/WB capture:
  - On every edge where stall_mem is 0, the register captures the current op, or a bubble if valid_mem is 0.
  - While stall_mem is 1, it captures a bubble: valid_wb = 0 and wb_reg_file_wb = 0.
- Latency:
  - Non-memory op: 1 cycle.
  - Store accepted in IDLE: 1 cycle.
  - Load with zero-wait memory: 2 cycles, with one stall cycle.
  - Each extra ready or response wait cycle adds 1.
- All request outputs stay stable while dmem_req_valid is 1 and dmem_req_ready is 0. EX/MEM is held by stall_mem.
- Reset, asynchronous:
  - FSM goes to IDLE.
  - All MEM/WB outputs and misaligned_wb go to 0.
  - dmem_req_valid goes to 0.
  - The registered offset and load type go to 0.
- Reset during REQ or RSP abandons the transaction. A late dmem_rsp_valid after reset is ignored.

## Structure
- mem_pkg holds:
  - load and store type localparams, shared with the decoder and EX stage;
  - the FSM state enum;
  - the misalignment check function.
- Sub-module load_extend is purely combinational: inputs are rdata, offset and load type; output is 32-bit data.
- The FSM, store lane logic and MEM/WB register stay in the top module.

## Test plan
- ALU op (add result 0x0000_1234), no memory op → alu_result_wb = 0x1234 next cycle, stall_mem never asserted.
- SB at address 0x1003, rs2 = 0xAABBCCDD, ready = 1 → wstrb = 1000, wdata = 0xDDDDDDDD, no stall.
- LB at address 0x2002, ready = 1, response one cycle later with rdata = 0x0080_0000 → one stall cycle, then load_data_wb = 0xFFFF_FF80. Repeat as LBU → 0x0000_0080.
- LW with ready held at 0 for 3 cycles and a response 2 cycles later → stall_mem high for 5 cycles, request fields stable throughout, bubbles enter WB, final load_data_wb = rdata.
- LH at address 0x0001 → no dmem_req_valid, no stall, misaligned_wb = 1, wb_reg_file_wb = 0.
- rst_n pulled low while in RSP, then a stray dmem_rsp_valid → FSM in IDLE, all outputs 0, the stray response is ignored.
